// File: rtl/varis_kontrol_pkg.sv
// varis_kontrol_pkg: shared airport constants (FSM encodings, duty threshold, widths)
// and the customs duty helper used on the arrival side.
package varis_kontrol_pkg;

    typedef enum logic [2:0] {
        BEKLE    = 3'd0,
        ALIM     = 3'd1,
        PASAPORT = 3'd2,
        BAVUL    = 3'd3,
        GUMRUK   = 3'd4,
        SONUC    = 3'd5,
        BITTI    = 3'd6
    } durum_e;

    localparam int BIT_VARSAYILAN  = 6;
    localparam int YBIT_VARSAYILAN = 5;
    localparam int ESIK_VARSAYILAN = 100;

    // beyan and esik are both 9-bit, so the shifted difference always fits
    function automatic logic [8:0] vergi_hesapla(input logic [8:0] beyan, input logic [8:0] esik);
        return (beyan > esik) ? (beyan - esik) >> 2 : 9'd0;
    endfunction

endpackage

// File: rtl/varis_kontrol_pasaport_kontrol.sv
// pasaport_kontrol: ID validity check with a 1-cycle (citizen) or 2-cycle (foreign)
// latency; bitti pulses in the last passport cycle together with a stable gecerli.
module pasaport_kontrol #(
    parameter int BIT = 6
) (
    input  logic           saat,
    input  logic           reset,
    input  logic           start,
    input  logic [BIT-1:0] kimlik_no,
    input  logic           uyruk,
    output logic           bitti,
    output logic           gecerli
);

    logic [1:0] kalan_q, kalan_d;
    logic       gecerli_q, gecerli_d;

    always_comb begin
        kalan_d   = (kalan_q != 2'd0) ? kalan_q - 2'd1 : kalan_q;
        gecerli_d = gecerli_q;
        if (start) begin
            kalan_d   = uyruk ? 2'd2 : 2'd1;
            gecerli_d = !((kimlik_no == '0) || (kimlik_no == '1));
        end
    end

    always_ff @(posedge saat) begin
        if (reset) begin
            kalan_q   <= 2'd0;
            gecerli_q <= 1'b0;
        end else begin
            kalan_q   <= kalan_d;
            gecerli_q <= gecerli_d;
        end
    end

    assign bitti   = (kalan_q == 2'd1);
    assign gecerli = gecerli_q;

endmodule

// File: rtl/varis_kontrol.sv
// varis_kontrol: arrival-side passenger processing (passport -> baggage -> customs)
// for one landed aircraft at a time; all outputs are registered.
module varis_kontrol
    import varis_kontrol_pkg::*;
#(
    parameter int         BIT  = BIT_VARSAYILAN,
    parameter int         YBIT = YBIT_VARSAYILAN,
    parameter logic [8:0] ESIK = 9'(ESIK_VARSAYILAN)
) (
    input  logic            saat,
    input  logic            reset,
    input  logic            inis,
    input  logic [YBIT-1:0] yolcu_sayisi,
    input  logic            yolcu_gecerli,
    output logic            yolcu_hazir,
    input  logic [BIT-1:0]  kimlik_no,
    input  logic            uyruk,
    input  logic [2:0]      bavul_adet,
    input  logic [8:0]      beyan,
    output logic            sonuc_gecerli,
    output logic            giris,
    output logic [8:0]      gumruk_vergi,
    output logic [YBIT-1:0] reddedilen,
    output logic            tahliye_bitti
);

    durum_e          durum_q, durum_d;
    logic [YBIT-1:0] sayi_q, sayi_d;
    logic [YBIT-1:0] islenen_q, islenen_d;
    logic [YBIT-1:0] red_q, red_d;
    logic [2:0]      bavul_q, bavul_d;
    logic [8:0]      beyan_q, beyan_d;
    logic            giris_q, giris_d;
    logic [8:0]      vergi_q, vergi_d;
    logic            hazir_q, sonuc_q, bitti_q;
    logic            aktar, p_bitti, p_gecerli;

    assign aktar = (durum_q == ALIM) && hazir_q && yolcu_gecerli;

    pasaport_kontrol #(.BIT(BIT)) u_pasaport (
        .saat     (saat),
        .reset    (reset),
        .start    (aktar),
        .kimlik_no(kimlik_no),
        .uyruk    (uyruk),
        .bitti    (p_bitti),
        .gecerli  (p_gecerli)
    );

    always_comb begin
        durum_d   = durum_q;
        sayi_d    = sayi_q;
        islenen_d = islenen_q;
        red_d     = red_q;
        bavul_d   = bavul_q;
        beyan_d   = beyan_q;
        case (durum_q)
            BEKLE: if (inis) begin
                sayi_d    = yolcu_sayisi;
                islenen_d = '0;
                red_d     = '0;
                durum_d   = (yolcu_sayisi == '0) ? BITTI : ALIM;
            end
            ALIM: if (aktar) begin
                bavul_d = bavul_adet;
                beyan_d = beyan;
                durum_d = PASAPORT;
            end
            PASAPORT: if (p_bitti) begin
                if (!p_gecerli) begin
                    red_d   = (red_q == '1) ? red_q : red_q + 1'b1;
                    durum_d = SONUC;
                end else begin
                    durum_d = (bavul_q == 3'd0) ? GUMRUK : BAVUL;
                end
            end
            BAVUL: begin
                durum_d = (bavul_q == 3'd1) ? GUMRUK : BAVUL;
                bavul_d = bavul_q - 3'd1;
            end
            GUMRUK: durum_d = SONUC;
            SONUC: begin
                islenen_d = islenen_q + 1'b1;
                durum_d   = (({1'b0, islenen_q} + 1'b1) == {1'b0, sayi_q}) ? BITTI : ALIM;
            end
            BITTI:   durum_d = BEKLE;
            default: durum_d = BEKLE;
        endcase
        // Result fields only change on entry to SONUC; a rejection arrives straight from PASAPORT
        giris_d = (durum_d == SONUC) ? (durum_q == GUMRUK) : giris_q;
        vergi_d = (durum_d != SONUC) ? vergi_q :
                  (durum_q == GUMRUK) ? vergi_hesapla(beyan_q, ESIK) : 9'd0;
    end

    always_ff @(posedge saat) begin
        if (reset) begin
            durum_q   <= BEKLE;
            sayi_q    <= '0;
            islenen_q <= '0;
            red_q     <= '0;
            bavul_q   <= '0;
            beyan_q   <= '0;
            giris_q   <= 1'b0;
            vergi_q   <= '0;
            hazir_q   <= 1'b0;
            sonuc_q   <= 1'b0;
            bitti_q   <= 1'b0;
        end else begin
            durum_q   <= durum_d;
            sayi_q    <= sayi_d;
            islenen_q <= islenen_d;
            red_q     <= red_d;
            bavul_q   <= bavul_d;
            beyan_q   <= beyan_d;
            giris_q   <= giris_d;
            vergi_q   <= vergi_d;
            hazir_q   <= (durum_d == ALIM);
            sonuc_q   <= (durum_d == SONUC);
            bitti_q   <= (durum_d == BITTI);
        end
    end

    assign yolcu_hazir   = hazir_q;
    assign sonuc_gecerli = sonuc_q;
    assign giris         = giris_q;
    assign gumruk_vergi  = vergi_q;
    assign reddedilen    = red_q;
    assign tahliye_bitti = bitti_q;

endmodule

// File: tb/tb_varis_kontrol.sv
// tb_varis_kontrol: vector table, hand-written corner sequences and randomized aircraft
// checked against a latency/duty model derived from the passenger rules.
module tb_varis_kontrol;

    typedef struct {
        logic [5:0] k;
        logic       u;
        logic [2:0] b;
        logic [8:0] y;
    } yolcu_t;

    typedef struct {
        yolcu_t r;
        int     gec;
        int     g;
        int     v;
        int     red;
    } vek_t;

    logic       saat = 1'b0;
    logic       reset = 1'b1;
    logic       inis = 1'b0;
    logic [4:0] yolcu_sayisi = '0;
    logic       yolcu_gecerli = 1'b0;
    logic       yolcu_hazir;
    logic [5:0] kimlik_no = '0;
    logic       uyruk = 1'b0;
    logic [2:0] bavul_adet = '0;
    logic [8:0] beyan = '0;
    logic       sonuc_gecerli, giris, tahliye_bitti;
    logic [8:0] gumruk_vergi;
    logic [4:0] reddedilen;

    int gecen = 0;
    int toplam = 0;

    always #5 saat = ~saat;

    varis_kontrol dut (
        .saat         (saat),
        .reset        (reset),
        .inis         (inis),
        .yolcu_sayisi (yolcu_sayisi),
        .yolcu_gecerli(yolcu_gecerli),
        .yolcu_hazir  (yolcu_hazir),
        .kimlik_no    (kimlik_no),
        .uyruk        (uyruk),
        .bavul_adet   (bavul_adet),
        .beyan        (beyan),
        .sonuc_gecerli(sonuc_gecerli),
        .giris        (giris),
        .gumruk_vergi (gumruk_vergi),
        .reddedilen   (reddedilen),
        .tahliye_bitti(tahliye_bitti)
    );

    task automatic tick;
        @(posedge saat);
        #1;
    endtask

    task automatic chk(input string ad, input int gercek, input int beklenen);
        toplam++;
        if (gercek == beklenen) gecen++;
        else $display("FAIL %s: got %0d expected %0d", ad, gercek, beklenen);
    endtask

    function automatic bit gecersiz(input logic [5:0] k);
        return k == 6'd0 || k == 6'd63;
    endfunction

    function automatic int m_gecikme(input yolcu_t r);
        int p = r.u ? 2 : 1;
        return gecersiz(r.k) ? p + 1 : p + int'(r.b) + 2;
    endfunction

    function automatic int m_vergi(input yolcu_t r);
        if (gecersiz(r.k) || int'(r.y) <= 100) return 0;
        return (int'(r.y) - 100) / 4;
    endfunction

    task automatic ucak_basla(input int n);
        yolcu_sayisi = 5'(n);
        inis = 1'b1;
        tick;
        inis = 1'b0;
    endtask

    task automatic ucak_bitir(input int red);
        chk("tahliye", tahliye_bitti, 1);
        chk("hazir_bitti", yolcu_hazir, 0);
        chk("red_bitti", reddedilen, red);
        tick;
        chk("tahliye_tek", tahliye_bitti, 0);
        chk("red_tut", reddedilen, red);
    endtask

    task automatic yolcu(input yolcu_t r, input int gec, input int g, input int v,
                         input int red, input int bekle);
        int w = 0;
        int l;
        while (!yolcu_hazir && w < 30) begin
            tick;
            w++;
        end
        chk("hazir", yolcu_hazir, 1);
        repeat (bekle) begin
            tick;
            chk("hazir_bekle", yolcu_hazir, 1);
        end
        kimlik_no = r.k;
        uyruk = r.u;
        bavul_adet = r.b;
        beyan = r.y;
        yolcu_gecerli = 1'b1;
        tick;
        yolcu_gecerli = 1'b0;
        l = 1;
        while (!sonuc_gecerli && l < 40) begin
            tick;
            l++;
        end
        chk("gecikme", l, gec);
        chk("giris", giris, g);
        chk("vergi", gumruk_vergi, v);
        chk("reddedilen", reddedilen, red);
    endtask

    initial begin
        vek_t   tablo[8];
        yolcu_t r;
        int     l, sp, red, n;

        tablo[0] = '{'{6'd5, 1'b0, 3'd2, 9'd180}, 5, 1, 20, 0};
        tablo[1] = '{'{6'd9, 1'b1, 3'd0, 9'd100}, 4, 1, 0, 0};
        tablo[2] = '{'{6'd0, 1'b0, 3'd3, 9'd300}, 2, 0, 0, 1};
        tablo[3] = '{'{6'd63, 1'b1, 3'd7, 9'd511}, 3, 0, 0, 1};
        tablo[4] = '{'{6'd62, 1'b0, 3'd1, 9'd101}, 4, 1, 0, 0};
        tablo[5] = '{'{6'd30, 1'b0, 3'd0, 9'd104}, 3, 1, 1, 0};
        tablo[6] = '{'{6'd7, 1'b1, 3'd3, 9'd0}, 7, 1, 0, 0};
        tablo[7] = '{'{6'd1, 1'b1, 3'd7, 9'd511}, 11, 1, 102, 0};

        repeat (3) tick;
        chk("rst_hazir", yolcu_hazir, 0);
        chk("rst_sonuc", sonuc_gecerli, 0);
        chk("rst_giris", giris, 0);
        chk("rst_vergi", gumruk_vergi, 0);
        chk("rst_red", reddedilen, 0);
        chk("rst_tahliye", tahliye_bitti, 0);
        reset = 1'b0;
        tick;

        foreach (tablo[i]) begin
            ucak_basla(1);
            yolcu(tablo[i].r, tablo[i].gec, tablo[i].g, tablo[i].v, tablo[i].red, 0);
            tick;
            chk("sonuc_tek", sonuc_gecerli, 0);
            ucak_bitir(tablo[i].red);
        end

        // two rejected IDs in one aircraft
        ucak_basla(2);
        r = '{6'd0, 1'b0, 3'd3, 9'd300};
        yolcu(r, 2, 0, 0, 1, 0);
        tick;
        r = '{6'd63, 1'b0, 3'd0, 9'd50};
        yolcu(r, 2, 0, 0, 2, 1);
        tick;
        ucak_bitir(2);

        // empty aircraft
        ucak_basla(0);
        ucak_bitir(0);

        // valid held high while busy, plus a stray landing pulse
        ucak_basla(2);
        chk("t5_hazir", yolcu_hazir, 1);
        kimlik_no = 6'd12; uyruk = 1'b1; bavul_adet = 3'd1; beyan = 9'd200;
        yolcu_gecerli = 1'b1;
        tick;
        kimlik_no = 6'd0; uyruk = 1'b0; bavul_adet = 3'd5; beyan = 9'd300;
        inis = 1'b1; yolcu_sayisi = 5'd9;
        tick;
        inis = 1'b0;
        l = 2;
        while (!sonuc_gecerli && l < 40) begin
            chk("t5_mesgul", yolcu_hazir, 0);
            tick;
            l++;
        end
        chk("t5_gecikme1", l, 5);
        chk("t5_giris1", giris, 1);
        chk("t5_vergi1", gumruk_vergi, 25);
        chk("t5_red1", reddedilen, 0);
        tick;
        chk("t5_hazir2", yolcu_hazir, 1);
        tick;
        yolcu_gecerli = 1'b0;
        l = 1;
        while (!sonuc_gecerli && l < 40) begin
            tick;
            l++;
        end
        chk("t5_gecikme2", l, 2);
        chk("t5_giris2", giris, 0);
        chk("t5_red2", reddedilen, 1);
        tick;
        ucak_bitir(1);

        // reset in the middle of baggage delivery; prior result has giris=1
        ucak_basla(1);
        r = '{6'd5, 1'b0, 3'd7, 9'd200};
        yolcu(r, 10, 1, 25, 0, 0);
        tick;
        ucak_bitir(0);
        ucak_basla(1);
        kimlik_no = r.k; uyruk = r.u; bavul_adet = r.b; beyan = r.y;
        yolcu_gecerli = 1'b1;
        tick;
        yolcu_gecerli = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("t6_hazir", yolcu_hazir, 0);
        chk("t6_sonuc", sonuc_gecerli, 0);
        chk("t6_giris", giris, 0);
        chk("t6_vergi", gumruk_vergi, 0);
        chk("t6_red", reddedilen, 0);
        chk("t6_tahliye", tahliye_bitti, 0);
        sp = 0;
        repeat (15) begin
            tick;
            if (sonuc_gecerli || yolcu_hazir || tahliye_bitti) sp++;
        end
        chk("t6_sessiz", sp, 0);
        ucak_basla(1);
        yolcu(r, 10, 1, 25, 0, 0);
        tick;
        ucak_bitir(0);

        // randomized aircraft against the model
        repeat (25) begin
            n = $urandom_range(0, 4);
            red = 0;
            ucak_basla(n);
            for (int i = 0; i < n; i++) begin
                r.k = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 6'd63 : 6'd0)
                                                 : 6'($urandom_range(0, 63));
                r.u = 1'($urandom_range(0, 1));
                r.b = 3'($urandom_range(0, 7));
                r.y = 9'($urandom_range(0, 511));
                if (gecersiz(r.k)) red++;
                yolcu(r, m_gecikme(r), gecersiz(r.k) ? 0 : 1, m_vergi(r), red,
                      $urandom_range(0, 2));
                tick;
                chk("rnd_sonuc_tek", sonuc_gecerli, 0);
            end
            ucak_bitir(red);
        end

        $display("%0d/%0d checks passed", gecen, toplam);
        $finish;
    end

endmodule
